imm_extend_pipe: RTL and testbench

- Parametrised, buffered successor to the fixed 16->32 immediate extender.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero-extend, sign-extend, upper-place (LUI-style), or fill with an explicit extension bit.
- Results are queued in a DEPTH-entry FIFO behind a valid/ready handshake.
- Sits between instruction decode and the ALU operand mux in the multi-cycle datapath.

---
 rtl/imm_extend_pipe_pkg.sv | 45 ++++
 rtl/imm_extend_pipe_if.sv | 27 ++
 rtl/imm_extend_pipe_ext_fifo.sv | 52 +++++
 rtl/imm_extend_pipe.sv | 55 +++++
 tb/tb_imm_extend_pipe.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared types and the width-generic immediate extension function for imm_extend_pipe.
// ext_value works on a MaxW-bit container; callers truncate the result to their OUT_W.
package imm_ext_pkg;

   typedef enum logic [1:0] {
      MODE_ZERO     = 2'b00,
      MODE_SIGN     = 2'b01,
      MODE_UPPER    = 2'b10,
      MODE_EXPLICIT = 2'b11
   } mode_e;

   localparam int unsigned MaxW    = 64;
   localparam int unsigned MaxIdxW = $clog2(MaxW);

   function automatic logic [MaxW-1:0] ext_value(input logic [MaxW-1:0] imm,
                                                 input mode_e           mode,
                                                 input logic            ext,
                                                 input int unsigned     in_w,
                                                 input int unsigned     out_w);
      logic [MaxW-1:0] res;
      logic            fill;
      int              e;
      e = int'(out_w) - int'(in_w);
      case (mode)
         MODE_SIGN:     fill = imm[MaxIdxW'(in_w - 1)];
         MODE_EXPLICIT: fill = ext;
         default:       fill = 1'b0;
      endcase
      res = '0;
      for (int i = 0; i < int'(MaxW); i++) begin
         if (i < int'(out_w)) begin
            // Upper placement shifts by E; with E=0 it degenerates to a plain copy.
            if (mode == MODE_UPPER) begin
               if (i >= e) res[MaxIdxW'(i)] = imm[MaxIdxW'(i - e)];
            end else if (i < int'(in_w)) begin
               res[MaxIdxW'(i)] = imm[MaxIdxW'(i)];
            end else begin
               res[MaxIdxW'(i)] = fill;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Request/response handshake bundle for imm_extend_pipe.
// slave is the extender's view; master is the decode/ALU side driving it.
interface imm_extend_pipe_if
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   mode_e            in_mode;
   logic             in_ext;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;

   modport slave (
      input  in_valid, in_imm, in_mode, in_ext, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_imm, in_mode, in_ext, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/imm_extend_pipe_ext_fifo.sv
// Generic synchronous FIFO with async active-low reset; accepts a push while full
// provided a pop happens in the same cycle. Occupancy alone separates full from empty.
module ext_fifo #(
   parameter int unsigned  Width = 32,
   parameter int unsigned  Depth = 4,
   localparam int unsigned AW    = $clog2(Depth),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push_valid,
   output logic             o_push_ready,
   input  logic [Width-1:0] i_push_data,
   output logic             o_pop_valid,
   input  logic             i_pop_ready,
   output logic [Width-1:0] o_pop_data,
   output logic [CW-1:0]    o_count
);
   logic [Width-1:0] r_mem [Depth];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_live;
   logic             w_push;
   logic             w_pop;

   // r_live keeps the input closed until the first edge after reset release.
   assign o_push_ready = r_live && ((r_count < CW'(Depth)) || i_pop_ready);
   assign o_pop_valid  = (r_count != '0);
   assign o_pop_data   = o_pop_valid ? r_mem[r_rptr] : '0;
   assign o_count      = r_count;
   assign w_push       = i_push_valid && o_push_ready;
   assign w_pop        = o_pop_valid && i_pop_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live  <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_push_data;
   end
endmodule

// File: rtl/imm_extend_pipe.sv
// Buffered immediate extender: widens IN_W->OUT_W by mode and queues results in a FIFO.
// Extension happens before storage so the FIFO holds finished OUT_W operands.
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W         = 16,
   parameter int unsigned OUT_W        = 32,
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] ACC_CNT_INIT = '0  // accepted_cnt reset value, normally 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   imm_extend_pipe_if.slave       bus,
   output logic [$clog2(DEPTH):0] count,
   output logic [31:0]            accepted_cnt
);
   if (OUT_W < IN_W) begin : g_bad_width
      $error("imm_extend_pipe: OUT_W must be >= IN_W");
   end
   if (OUT_W > MaxW || IN_W < 1) begin : g_bad_range
      $error("imm_extend_pipe: widths out of supported range");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("imm_extend_pipe: DEPTH must be a power of two >= 2");
   end

   logic [OUT_W-1:0] w_ext;
   logic             w_push;
   logic [31:0]      r_acc_cnt;

   assign w_ext  = OUT_W'(ext_value(MaxW'(bus.in_imm), bus.in_mode, bus.in_ext, IN_W, OUT_W));
   assign w_push = bus.in_valid && bus.in_ready;

   ext_fifo #(
      .Width (OUT_W),
      .Depth (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push_valid (bus.in_valid),
      .o_push_ready (bus.in_ready),
      .i_push_data  (w_ext),
      .o_pop_valid  (bus.out_valid),
      .i_pop_ready  (bus.out_ready),
      .o_pop_data   (bus.out_data),
      .o_count      (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc_cnt <= ACC_CNT_INIT;
      else if (w_push) r_acc_cnt <= r_acc_cnt + 32'd1;
   end

   assign accepted_cnt = r_acc_cnt;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: a 16->32 depth-4 instance and an 8->8 depth-2
// instance whose accepted_cnt starts near the wrap point.
module tb_imm_extend_pipe;
   import imm_ext_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [2:0]  a_count;
   logic [31:0] a_acc;
   logic [1:0]  b_count;
   logic [31:0] b_acc;
   int          n_checks;
   int          n_pass;

   imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) a_if ();
   imm_extend_pipe_if #(.IN_W(8),  .OUT_W(8))  b_if ();

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(4)) u_dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (a_if.slave),
      .count        (a_count),
      .accepted_cnt (a_acc)
   );

   imm_extend_pipe #(.IN_W(8), .OUT_W(8), .DEPTH(2), .ACC_CNT_INIT(32'hFFFF_FFFE)) u_dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (b_if.slave),
      .count        (b_count),
      .accepted_cnt (b_acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   mode_e       modes   [4] = '{MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_EXPLICIT};
   logic [31:0] exp_a   [4] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFF_8001};
   logic [31:0] exp_acc [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002};

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      a_if.in_valid = 1'b0; a_if.in_imm = '0; a_if.in_mode = MODE_ZERO;
      a_if.in_ext   = 1'b0; a_if.out_ready = 1'b0;
      b_if.in_valid = 1'b0; b_if.in_imm = '0; b_if.in_mode = MODE_ZERO;
      b_if.in_ext   = 1'b0; b_if.out_ready = 1'b0;

      // Reset held for three cycles
      repeat (3) tick();
      chk("rst_out_valid", 64'(a_if.out_valid), 64'(0));
      chk("rst_out_data",  64'(a_if.out_data),  64'(0));
      chk("rst_count",     64'(a_count),        64'(0));
      chk("rst_acc",       64'(a_acc),          64'(0));
      chk("rst_in_ready",  64'(a_if.in_ready),  64'(0));
      chk("rst_b_acc",     64'(b_acc),          64'h0000_0000_FFFF_FFFE);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", 64'(a_if.in_ready), 64'(0));
      tick();
      chk("rel_in_ready_high", 64'(a_if.in_ready), 64'(1));

      // Four modes on 0x8001 with ext=1
      a_if.out_ready = 1'b1;
      a_if.in_valid  = 1'b1;
      a_if.in_imm    = 16'h8001;
      a_if.in_ext    = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a_if.in_mode = modes[k];
         tick();
         chk("mode_valid", 64'(a_if.out_valid), 64'(1));
         chk("mode_data",  64'(a_if.out_data),  64'(exp_a[k]));
      end
      a_if.in_valid = 1'b0;
      tick();
      chk("mode_count_empty", 64'(a_count),       64'(0));
      chk("mode_valid_low",   64'(a_if.out_valid), 64'(0));
      chk("mode_acc",         64'(a_acc),          64'(4));

      // Fill to DEPTH, then push-with-pop while full
      a_if.out_ready = 1'b0;
      a_if.in_mode   = MODE_ZERO;
      a_if.in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         a_if.in_imm = 16'(i);
         tick();
      end
      chk("full_count", 64'(a_count), 64'(4));
      a_if.in_imm = 16'h0005;
      #1;
      chk("full_in_ready_low", 64'(a_if.in_ready), 64'(0));
      chk("full_head",         64'(a_if.out_data), 64'(1));
      a_if.out_ready = 1'b1;
      #1;
      chk("full_in_ready_comb", 64'(a_if.in_ready), 64'(1));
      tick();
      a_if.in_valid = 1'b0;
      chk("full_count_kept", 64'(a_count), 64'(4));
      for (int k = 2; k <= 5; k++) begin
         chk("full_drain", 64'(a_if.out_data), 64'(k));
         tick();
      end
      chk("full_drained", 64'(a_count), 64'(0));
      chk("full_acc",     64'(a_acc),   64'(9));

      // Continuous push/pop across several pointer wraps
      a_if.in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         a_if.in_imm = 16'(16'h0100 + i);
         tick();
         chk("wrap_data",  64'(a_if.out_data), 64'(32'h0000_0100 + i));
         chk("wrap_count", 64'(a_count),       64'(1));
      end
      a_if.in_valid = 1'b0;
      tick();
      chk("wrap_empty", 64'(a_count), 64'(0));
      chk("wrap_acc",   64'(a_acc),   64'(21));

      // Reset pulse between edges with three entries queued
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      for (int i = 10; i <= 12; i++) begin
         a_if.in_imm = 16'(i);
         tick();
      end
      a_if.in_valid = 1'b0;
      chk("mid_count_pre", 64'(a_count), 64'(3));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_count",    64'(a_count),        64'(0));
      chk("mid_valid",    64'(a_if.out_valid), 64'(0));
      chk("mid_data",     64'(a_if.out_data),  64'(0));
      chk("mid_in_ready", 64'(a_if.in_ready),  64'(0));
      #2 rst_n = 1'b1;
      tick();
      chk("mid_in_ready_back", 64'(a_if.in_ready), 64'(1));
      a_if.in_valid = 1'b1;
      a_if.in_mode  = MODE_SIGN;
      a_if.in_imm   = 16'h1234;
      tick();
      a_if.in_valid = 1'b0;
      chk("mid_push_data", 64'(a_if.out_data), 64'h0000_0000_0000_1234);
      chk("mid_acc",       64'(a_acc),         64'(1));
      a_if.out_ready = 1'b1;
      tick();

      // Degenerate 8->8 widths and accepted_cnt wrap
      b_if.out_ready = 1'b1;
      b_if.in_valid  = 1'b1;
      b_if.in_imm    = 8'hA5;
      b_if.in_ext    = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b_if.in_mode = modes[k];
         tick();
         chk("deg_data", 64'(b_if.out_data), 64'h0000_0000_0000_00A5);
         chk("deg_acc",  64'(b_acc),         64'(exp_acc[k]));
      end
      b_if.in_valid = 1'b0;
      tick();
      chk("deg_empty", 64'(b_count), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
